// File: rtl/mrr_symbol_demod.sv
// Symbol demodulator behind the MRR correlator: windowed peak detection with jitter
// re-alignment, MSB-first byte packing, and a 4-entry AXI-stream byte FIFO.
module mrr_symbol_demod #(
    parameter int ESAMP_WIDTH             = 16,
    parameter int OVERSAMPLING_RATIO_LOG2 = 2,
    parameter int CNT_WIDTH               = 18,
    parameter int LEN_WIDTH               = 8,
    parameter int FIFO_DEPTH_LOG2         = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ESAMP_WIDTH-1:0] i_tdata,
    input  logic                   i_tvalid,
    input  logic                   i_tkeep,
    input  logic                   i_replay_header_flag,
    input  logic                   syncd_flag,
    input  logic [14:0]            recharge_len,
    input  logic [7:0]             max_jitter,
    input  logic [LEN_WIDTH-1:0]   payload_len,
    output logic [7:0]             o_tdata,
    output logic                   o_tvalid,
    output logic                   o_tlast,
    input  logic                   o_tready,
    output logic                   decode_done,
    output logic                   abort,
    output logic                   overflow
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    typedef logic [CNT_WIDTH-1:0]       cnt_t;
    typedef logic [LEN_WIDTH-1:0]       len_t;
    typedef logic [FIFO_DEPTH_LOG2:0]   occ_t;
    typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
    typedef enum logic [1:0] {ST_IDLE, ST_TRACK, ST_DONE} state_t;

    state_t                 r_state;
    logic [ESAMP_WIDTH-1:0] r_thr, r_max;
    cnt_t                   r_cnt, r_m, r_lo, r_hi, r_j;
    len_t                   r_len_m1, r_byte_cnt;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;
    logic                   r_hdr_d, r_push, r_push_last;
    logic [7:0]             r_push_byte;

    logic                   w_s, w_capture, w_in_win, w_upd, w_dec, w_bit, w_hdr_fall;
    cnt_t                   w_p, w_m_new;
    logic [ESAMP_WIDTH-1:0] w_max_new;

    assign w_s        = i_tvalid & i_tkeep;
    assign w_p        = (cnt_t'(recharge_len) + cnt_t'(2)) << OVERSAMPLING_RATIO_LOG2;
    assign w_capture  = (r_state == ST_IDLE) && syncd_flag && w_s;
    assign w_hdr_fall = r_hdr_d & ~i_replay_header_flag;
    // The current sample takes part in its own decision, so fold it in combinationally.
    assign w_in_win   = (r_cnt >= r_lo) && (r_cnt <= r_hi);
    assign w_upd      = w_in_win && (i_tdata > r_max);
    assign w_max_new  = w_upd ? i_tdata : r_max;
    assign w_m_new    = w_upd ? r_cnt : r_m;
    assign w_dec      = (r_cnt == r_hi);
    assign w_bit      = (w_max_new >= r_thr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_thr <= '0; r_max <= '0;
            r_cnt <= '0; r_m <= '0; r_lo <= '0; r_hi <= '0; r_j <= '0;
            r_len_m1 <= '0; r_byte_cnt <= '0; r_bit_cnt <= '0; r_shift <= '0;
            r_hdr_d <= 1'b0; r_push <= 1'b0; r_push_last <= 1'b0; r_push_byte <= '0;
            abort <= 1'b0;
        end else begin
            r_hdr_d <= i_replay_header_flag;
            abort   <= 1'b0;
            r_push  <= 1'b0;
            case (r_state)
                ST_IDLE: if (w_capture) begin
                    r_thr      <= i_tdata >> 1;
                    r_cnt      <= cnt_t'(1);
                    r_lo       <= w_p - cnt_t'(max_jitter);
                    r_hi       <= w_p + cnt_t'(max_jitter);
                    r_j        <= cnt_t'(max_jitter);
                    r_len_m1   <= (payload_len == '0) ? '0 : payload_len - len_t'(1);
                    r_byte_cnt <= '0;
                    r_bit_cnt  <= '0;
                    r_max      <= '0;
                    r_m        <= '0;
                    r_state    <= ST_TRACK;
                end
                ST_TRACK: if (w_hdr_fall) begin
                    abort   <= 1'b1;
                    r_state <= ST_IDLE;
                end else if (w_s) begin
                    if (w_dec) begin
                        // A detected pulse re-centres the counter on its peak position.
                        r_cnt     <= w_bit ? (r_hi - w_m_new + cnt_t'(1)) : (r_j + cnt_t'(1));
                        r_max     <= '0;
                        r_m       <= '0;
                        r_shift   <= {r_shift[5:0], w_bit};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_push      <= 1'b1;
                            r_push_byte <= {r_shift, w_bit};
                            r_push_last <= (r_byte_cnt == r_len_m1);
                            r_byte_cnt  <= r_byte_cnt + len_t'(1);
                            if (r_byte_cnt == r_len_m1) r_state <= ST_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + cnt_t'(1);
                        r_max <= w_max_new;
                        r_m   <= w_m_new;
                    end
                end
                ST_DONE: if (!i_replay_header_flag) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    logic [8:0] r_mem [DEPTH];
    ptr_t       r_wr, r_rd, w_rd_next;
    occ_t       r_count, w_occ_after_pop;
    logic       w_pop, w_full, w_wr_ok;

    assign w_pop           = o_tvalid & o_tready;
    assign w_full          = (r_count == occ_t'(DEPTH));
    assign w_wr_ok         = r_push & (~w_full | w_pop);
    assign w_rd_next       = r_rd + ptr_t'(w_pop);
    assign w_occ_after_pop = r_count - occ_t'(w_pop);

    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_wr] <= {r_push_last, r_push_byte};
    end

    // The output register reads the FIFO head in place, so it is part of the 4-entry budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0; r_rd <= '0; r_count <= '0;
            o_tvalid <= 1'b0; o_tdata <= '0; o_tlast <= 1'b0;
            decode_done <= 1'b0; overflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr <= r_wr + ptr_t'(1);
            r_rd     <= w_rd_next;
            r_count  <= w_occ_after_pop + occ_t'(w_wr_ok);
            o_tvalid <= (w_occ_after_pop != '0);
            if (w_occ_after_pop != '0) {o_tlast, o_tdata} <= r_mem[w_rd_next];
            decode_done <= r_push & r_push_last;
            if (r_push & ~w_wr_ok) overflow <= 1'b1;
            else if (w_capture)    overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mrr_symbol_demod.sv
// Scoreboard bench for mrr_symbol_demod: expected bytes are queued when a frame is
// driven and compared by a monitor on each AXI-stream transfer.
module tb_mrr_symbol_demod;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] i_tdata;
    logic        i_tvalid, i_tkeep, i_replay_header_flag, syncd_flag;
    logic [14:0] recharge_len;
    logic [7:0]  max_jitter;
    logic [7:0]  payload_len;
    logic [7:0]  o_tdata;
    logic        o_tvalid, o_tlast, o_tready, decode_done, abort, overflow;

    always #5 clk = ~clk;

    mrr_symbol_demod dut (
        .clk(clk), .rst(rst), .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tkeep(i_tkeep),
        .i_replay_header_flag(i_replay_header_flag), .syncd_flag(syncd_flag),
        .recharge_len(recharge_len), .max_jitter(max_jitter), .payload_len(payload_len),
        .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_tready(o_tready),
        .decode_done(decode_done), .abort(abort), .overflow(overflow)
    );

    typedef logic [8:0] exp_t;
    exp_t       sb_q[$];
    exp_t       sb_e;
    bit         sb_free = 1'b0;
    int         errors = 0, checks = 0;
    int         rx_count = 0, cyc = 0, done_cyc = -10, rise_cyc = -10, done_cnt = 0, abort_cnt = 0;
    logic [7:0] last_rx = '0;
    logic       last_rx_last = 1'b0, prev_vld = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (decode_done) begin done_cnt++; done_cyc = cyc; end
            if (abort) abort_cnt++;
            if (o_tvalid && !prev_vld) rise_cyc = cyc;
            if (o_tvalid && o_tready) begin
                rx_count++; last_rx = o_tdata; last_rx_last = o_tlast;
                if (sb_q.size() > 0) begin
                    sb_e = sb_q.pop_front();
                    checks++;
                    if ({o_tlast, o_tdata} !== sb_e) begin
                        errors++;
                        $display("FAIL sb_byte: got last=%0b data=%02h, want last=%0b data=%02h", o_tlast, o_tdata, sb_e[8], sb_e[7:0]);
                    end
                end else if (!sb_free) begin
                    checks++; errors++;
                    $display("FAIL sb_unexpected: got data=%02h last=%0b with nothing expected", o_tdata, o_tlast);
                end
            end
            prev_vld = o_tvalid;
        end else prev_vld = 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive_s(input int d, input int gap);
        i_tvalid = 1'b1; i_tkeep = 1'b1; i_tdata = 16'(d);
        tick();
        syncd_flag = 1'b0;
        for (int g = 0; g < gap; g++) begin
            i_tvalid = (g % 2 == 0); i_tkeep = 1'b0; i_tdata = 16'hFFFF;
            tick();
        end
        i_tvalid = 1'b0; i_tkeep = 1'b0;
    endtask

    // Sync sample of 1000, then one symbol per 'spacing' samples, MSB-first from bits[nbits-1].
    task automatic run_stream(input logic [63:0] bits, input int nbits, input int spacing,
                              input int amp1, input int amp0, input int gap, input int tail);
        i_replay_header_flag = 1'b1; syncd_flag = 1'b1;
        drive_s(1000, gap);
        for (int b = nbits - 1; b >= 0; b--) begin
            for (int k = 0; k < spacing - 1; k++) drive_s(50, gap);
            drive_s(bits[b] ? amp1 : amp0, gap);
        end
        for (int k = 0; k < tail; k++) drive_s(50, gap);
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_count < target && n < budget) begin tick(); n++; end
    endtask

    task automatic end_frame();
        i_tvalid = 1'b0; i_replay_header_flag = 1'b0;
        tick(); tick();
        i_replay_header_flag = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (3) tick(); rst = 1'b0; tick();
        checks++;
        if ({o_tvalid, o_tlast, o_tdata} !== 10'd0) begin
            errors++; $display("FAIL reset_stream: got valid=%0b last=%0b data=%02h, want 0 0 00", o_tvalid, o_tlast, o_tdata);
        end
        checks++;
        if ({decode_done, abort, overflow} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got done/abort/ovf=%03b, want 000", {decode_done, abort, overflow});
        end
    endtask

    task automatic test_basic();
        int base = rx_count, d0 = done_cnt;
        recharge_len = 15'd2; max_jitter = 8'd2; payload_len = 8'd1; o_tready = 1'b1;
        sb_q.push_back({1'b1, 8'hA5});
        run_stream(64'hA5, 8, 16, 900, 50, 0, 4);
        wait_rx(base + 1, 50);
        checks++;
        if (rx_count !== base + 1) begin errors++; $display("FAIL basic_count: got %0d bytes, want %0d", rx_count - base, 1); end
        checks++;
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL basic_done: got %0d pulses, want 1", done_cnt - d0); end
        checks++;
        if (rise_cyc - done_cyc !== 1) begin errors++; $display("FAIL basic_latency: valid rose %0d clk after done, want 1", rise_cyc - done_cyc); end
        end_frame();
    endtask

    task automatic test_jitter();
        int base = rx_count;
        sb_q.push_back({1'b1, 8'hFF});
        run_stream(64'hFF, 8, 18, 900, 50, 0, 4);
        wait_rx(base + 1, 50);
        checks++;
        if (rx_count !== base + 1) begin errors++; $display("FAIL jitter2_count: got %0d bytes, want 1", rx_count - base); end
        end_frame();
        base = rx_count; sb_free = 1'b1;
        run_stream(64'hFF, 8, 19, 900, 50, 0, 4);
        wait_rx(base + 1, 50);
        checks++;
        if (rx_count !== base + 1) begin errors++; $display("FAIL jitter3_count: got %0d bytes, want 1", rx_count - base); end
        checks++;
        if (last_rx === 8'hFF) begin errors++; $display("FAIL jitter3_err: got data=%02h, want a byte other than ff", last_rx); end
        checks++;
        if (last_rx_last !== 1'b1) begin errors++; $display("FAIL jitter3_last: got %0b want 1", last_rx_last); end
        sb_free = 1'b0;
        end_frame();
    endtask

    task automatic test_threshold();
        int base = rx_count;
        payload_len = 8'd2;
        sb_q.push_back({1'b0, 8'hF0});
        sb_q.push_back({1'b1, 8'h0F});
        run_stream(64'hF00F, 16, 16, 500, 499, 0, 4);
        wait_rx(base + 2, 50);
        checks++;
        if (rx_count !== base + 2) begin errors++; $display("FAIL thresh_count: got %0d bytes, want 2", rx_count - base); end
        end_frame();
    endtask

    task automatic test_backpressure();
        int base = rx_count, d0 = done_cnt;
        payload_len = 8'd6; o_tready = 1'b0;
        sb_q.push_back({1'b0, 8'h11}); sb_q.push_back({1'b0, 8'h22});
        sb_q.push_back({1'b0, 8'h33}); sb_q.push_back({1'b0, 8'h44});
        run_stream(64'h112233445566, 48, 16, 900, 50, 0, 4);
        repeat (3) tick();
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %0b want 1", overflow); end
        checks++;
        if ({o_tvalid, o_tlast, o_tdata} !== {2'b10, 8'h11}) begin
            errors++; $display("FAIL bp_head: got valid=%0b last=%0b data=%02h, want 1 0 11", o_tvalid, o_tlast, o_tdata);
        end
        checks++;
        if (done_cnt !== d0 + 1) begin errors++; $display("FAIL bp_done: got %0d pulses, want 1", done_cnt - d0); end
        repeat (5) tick();
        checks++;
        if (o_tdata !== 8'h11) begin errors++; $display("FAIL bp_stable: got data=%02h want 11", o_tdata); end
        o_tready = 1'b1;
        wait_rx(base + 4, 30);
        repeat (5) tick();
        checks++;
        if (rx_count !== base + 4) begin errors++; $display("FAIL bp_count: got %0d bytes, want 4", rx_count - base); end
        checks++;
        if (o_tvalid !== 1'b0) begin errors++; $display("FAIL bp_drained: got valid=%0b want 0", o_tvalid); end
        end_frame();
    endtask

    task automatic test_abort();
        int base = rx_count, a0 = abort_cnt;
        payload_len = 8'd2;
        sb_q.push_back({1'b0, 8'hC3});
        run_stream(64'hC3A, 12, 16, 900, 50, 0, 4);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL sync_clears_ovf: got %0b want 0", overflow); end
        i_replay_header_flag = 1'b0;
        repeat (3) tick();
        checks++;
        if (abort_cnt !== a0 + 1) begin errors++; $display("FAIL abort_pulse: got %0d pulses, want 1", abort_cnt - a0); end
        wait_rx(base + 1, 20);
        repeat (3) tick();
        checks++;
        if (rx_count !== base + 1) begin errors++; $display("FAIL abort_count: got %0d bytes, want 1", rx_count - base); end
        i_replay_header_flag = 1'b1; tick();
        base = rx_count; payload_len = 8'd1;
        sb_q.push_back({1'b1, 8'h3C});
        run_stream(64'h3C, 8, 16, 900, 50, 0, 4);
        wait_rx(base + 1, 50);
        checks++;
        if (rx_count !== base + 1) begin errors++; $display("FAIL restart_count: got %0d bytes, want 1", rx_count - base); end
        checks++;
        if (abort_cnt !== a0 + 1) begin errors++; $display("FAIL restart_abort: got %0d pulses, want 1", abort_cnt - a0); end
        end_frame();
    endtask

    task automatic test_qual_reset();
        int base = rx_count;
        payload_len = 8'd0;
        sb_q.push_back({1'b1, 8'h5A});
        run_stream(64'h5A, 8, 16, 900, 50, 3, 4);
        wait_rx(base + 1, 100);
        checks++;
        if (rx_count !== base + 1) begin errors++; $display("FAIL qual_count: got %0d bytes, want 1", rx_count - base); end
        end_frame();
        base = rx_count; payload_len = 8'd6; o_tready = 1'b0;
        run_stream(64'h11223344556, 44, 16, 900, 50, 0, 0);
        checks++;
        if ({o_tvalid, overflow} !== 2'b11) begin errors++; $display("FAIL prerst_state: got valid/ovf=%02b want 11", {o_tvalid, overflow}); end
        rst = 1'b1; tick();
        checks++;
        if ({o_tvalid, o_tlast, o_tdata, decode_done, abort, overflow} !== 13'd0) begin
            errors++; $display("FAIL midrst_outputs: got valid=%0b last=%0b data=%02h done=%0b abort=%0b ovf=%0b, want all 0",
                               o_tvalid, o_tlast, o_tdata, decode_done, abort, overflow);
        end
        rst = 1'b0; o_tready = 1'b1;
        for (int k = 0; k < 40; k++) drive_s((k % 16 == 15) ? 900 : 50, 0);
        repeat (5) tick();
        checks++;
        if (rx_count !== base) begin errors++; $display("FAIL midrst_flush: got %0d bytes, want 0", rx_count - base); end
        payload_len = 8'd1;
        sb_q.push_back({1'b1, 8'h81});
        run_stream(64'h81, 8, 16, 900, 50, 0, 4);
        wait_rx(base + 1, 50);
        checks++;
        if (rx_count !== base + 1) begin errors++; $display("FAIL recover_count: got %0d bytes, want 1", rx_count - base); end
        end_frame();
    endtask

    initial begin
        rst = 1'b1; i_tdata = '0; i_tvalid = 1'b0; i_tkeep = 1'b0; i_replay_header_flag = 1'b1;
        syncd_flag = 1'b0; recharge_len = 15'd2; max_jitter = 8'd2; payload_len = 8'd1; o_tready = 1'b1;
        test_reset();
        test_basic();
        test_jitter();
        test_threshold();
        test_backpressure();
        test_abort();
        test_qual_reset();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending bytes, want 0", sb_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mrr_symbol_demod.md
# mrr_symbol_demod

Power-domain symbol demodulator that sits directly downstream of the MRR correlation stage. Once the correlator asserts `syncd_flag`, it tracks the pulse train on the replayed header/payload samples. It decides one bit per symbol period by windowed peak detection with jitter tracking, packs the bits MSB-first into bytes, and delivers them on an AXI-stream byte interface through a small FIFO.

## Interface
- `ESAMP_WIDTH`, 16: power-sample width (matches the correlator's `o_tdata`).
- `OVERSAMPLING_RATIO_LOG2`, 2: log2 of the samples per chip after resampling.
- `CNT_WIDTH`, 18: width of the sample-position counter.
- `LEN_WIDTH`, 8: width of the payload byte count.
- `FIFO_DEPTH_LOG2`, 2: output FIFO holds 4 bytes.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `i_tdata` in ESAMP_WIDTH: power sample from the correlator.
- `i_tvalid` in 1: sample valid.
- `i_tkeep` in 1: resampling strobe. A sample counts only when `i_tvalid & i_tkeep`.
- `i_replay_header_flag` in 1: header/payload replay active.
- `syncd_flag` in 1: correlator sync pulse. The qualified sample in that cycle is the first pulse centre.
- `recharge_len` in 15: symbol period control.
- `max_jitter` in 8: half-width J of the search window, in samples.
- `payload_len` in LEN_WIDTH: number of bytes to decode; 0 is treated as 1.
- `o_tdata` out 8: decoded byte.
- `o_tvalid` out 1: byte valid.
- `o_tlast` out 1: final byte of the payload.
- `o_tready` in 1: downstream ready.
- `decode_done` out 1: one-cycle pulse when the last byte enters the FIFO.
- `abort` out 1: one-cycle pulse when replay ends mid-payload.
- `overflow` out 1: sticky flag; cleared by `rst` or by the next `syncd_flag` capture.

## Operation
- Symbol period: P = (`recharge_len`+2) << OVERSAMPLING_RATIO_LOG2, computed in CNT_WIDTH bits.
- P, J, and `payload_len` are latched at sync capture. Requirement: 2J < P.
- The qualified strobe is s = `i_tvalid & i_tkeep`. Counters and the peak search advance only on s.

State machine:
- **IDLE**
  - When `syncd_flag & s`: latch ref = `i_tdata`, threshold = ref>>1, cnt = 1, bit/byte counters = 0, clear `overflow`, go to TRACK.
  - `syncd_flag` without s waits for the next s while the flag is still high.
- **TRACK**
  - cnt increments on each s.
  - While P−J ≤ cnt ≤ P+J, track the max sample and its cnt value m. Comparison is strict >, so on a tie the earliest sample wins.
  - At cnt == P+J the bit is decided: bit = (max ≥ threshold).
  - If bit = 1, the centre re-aligns: cnt ← P+J−m+1. If bit = 0, cnt ← J+1.
  - The max/m registers clear after each decision.
  - Bits shift into the byte register MSB-first. On the 8th bit the byte is pushed to the FIFO on the following cycle.
  - After `payload_len` bytes, go to DONE.
  - If `i_replay_header_flag` falls in TRACK: pulse `abort`, discard the partial byte, go to IDLE. Bytes already in the FIFO still drain, without `o_tlast`.
- **DONE**
  - Return to IDLE when `i_replay_header_flag` is low.

FIFO:
- Each entry is {last, byte}.
- A push while full drops the byte and sets `overflow`. A dropped last byte still pulses `decode_done`.
- A push and pop in the same cycle on a full FIFO succeeds.

## Timing
- Reset values: `o_tvalid`=0, `o_tlast`=0, `o_tdata`=0, `decode_done`=0, `abort`=0, `overflow`=0. State is IDLE, FIFO is empty.
- The decision is registered at the s-cycle where cnt reaches P+J.
- The byte is written to the FIFO 1 clk after its 8th decision; `decode_done` pulses in that same cycle.
- `o_tvalid` rises 1 clk after the write; first-word latency is 2 clk from the final decision.
- Standard AXI-stream handshake: a transfer occurs on `o_tvalid & o_tready`. `o_tdata`/`o_tlast` are held stable while `o_tvalid & !o_tready`.
- `rst` mid-operation empties the FIFO immediately and drops all in-flight bytes.
- `syncd_flag` outside IDLE is ignored.

## Test plan
- **Basic decode.** `recharge_len`=2, OSR_LOG2=2 (P=16), J=2, `payload_len`=1. Drive a sync sample of 1000, then pulses of 900 at 16-sample spacing for bit pattern 0xA5, with noise of 50 elsewhere. Expect one byte 0xA5 with `o_tlast`=1, and `decode_done` 1 clk before `o_tvalid`.
- **Jitter tracking.** Same setup, all-ones byte, each pulse 2 samples late (spacing 18). Expect 0xFF. Repeat with a 3-sample drift and expect an error bit.
- **Threshold boundary.** ref=1000. Pulses of 500 decode as 1 and pulses of 499 decode as 0; byte 0xF0 built from 500/499 pulses decodes as 0xF0.
- **Backpressure/overflow.** `payload_len`=6, `o_tready`=0 throughout. Expect 4 bytes held and `overflow`=1. Then release `o_tready`: exactly 4 bytes emerge, none with `o_tlast`.
- **Abort.** Drop `i_replay_header_flag` after 12 bits with `payload_len`=2. Expect one byte out without `o_tlast`, a single `abort` pulse, and return to IDLE. A following `syncd_flag` restarts decoding cleanly.
- **Qualification and reset.** Gaps with `i_tkeep`=0 between samples leave the decoded value unchanged. Asserting `rst` mid-byte returns all outputs to their reset values in the next cycle.
